sum_accumulator: RTL

- Downstream stage of the registered adder. Consumes its width+1-bit sum Y as a valid/ready stream.
- Accumulates a block of `count` consecutive sums into one result.
- Presents each block result on an output valid/ready handshake, together with a saturation flag and the number of samples in the block.
- Used to reduce adder output streams, e.g. for checksums and averaging, before they reach the capture logic.

---
 rtl/sum_accumulator_pkg.sv | 25 ++
 rtl/sat_add.sv | 27 ++
 rtl/sum_accumulator.sv | 119 +++++++++++
 3 files changed

// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg
// Shared types and constants for the sum accumulator block:
//   state_t - block FSM states (ACCUM collecting, HOLD result pending)
//   CNT_W   - width of the sample counter and of out_count (covers count up to 256)
//   clog2   - constant function used for elaboration-time parameter checks
package sum_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int CNT_W = 9;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_add.sv
// sat_add
// Combinational unsigned add of an a_width-bit operand onto an s_width-bit
// running value. The operand is zero-extended; if the true sum does not fit
// in s_width bits the result clamps to all-ones and sat is raised.
// Ports:
//   a   [s_width-1:0] running value (accumulator)
//   b   [a_width-1:0] operand to add
//   sum [s_width-1:0] clamped sum
//   sat               the addition overflowed s_width bits
module sat_add #(
    parameter int a_width = 33,
    parameter int s_width = 35
) (
    input  logic [s_width-1:0] a,
    input  logic [a_width-1:0] b,
    output logic [s_width-1:0] sum,
    output logic               sat
);

    logic [s_width:0] raw;

    // One guard bit above the result width catches the carry out.
    assign raw = {1'b0, a} + {{(s_width + 1 - a_width){1'b0}}, b};
    assign sat = raw[s_width];
    assign sum = sat ? {s_width{1'b1}} : raw[s_width-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator
// Accumulates blocks of `count` consecutive unsigned samples from the
// registered adder into one saturating sum, and hands each block result
// downstream on a valid/ready handshake with its sample count and a sticky
// saturation flag. A flush pulse closes a partial block early.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  sample handshake, Y_in [width:0] the sample
//   flush                close the current partial block
//   out_valid/out_ready  result handshake
//   out_sum [acc_width-1:0], out_count [8:0], out_sat  block result
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int width     = 32,
    parameter int count     = 4,
    parameter int acc_width = width + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width:0]       Y_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [acc_width-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_sat
);

    if (count < 1 || count > 256 || clog2(count + 1) > CNT_W || acc_width < width + 1) begin : g_param_err
        $error("sum_accumulator: illegal count or acc_width");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(count - 1);

    state_t               state_reg;
    logic [acc_width-1:0] acc_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 sat_reg;
    logic                 out_valid_reg;
    logic [acc_width-1:0] out_sum_reg;
    logic [CNT_W-1:0]     out_count_reg;
    logic                 out_sat_reg;

    logic [acc_width-1:0] add_sum;
    logic                 add_sat;
    logic                 accept;
    logic                 close_now;
    logic                 flush_only;

    sat_add #(
        .a_width(width + 1),
        .s_width(acc_width)
    ) u_add (
        .a  (acc_reg),
        .b  (Y_in),
        .sum(add_sum),
        .sat(add_sat)
    );

    // In HOLD a sample can only enter in the cycle the pending result leaves.
    // Held low during reset so the first ready cycle follows reset release.
    assign in_ready = !rst && ((state_reg == ACCUM) || out_ready);
    assign accept   = in_valid && in_ready;

    // The accumulator is empty in HOLD (cleared at close), so a sample taken
    // there starts a fresh block through the same adder path; with
    // count == 1 (LAST == 0) or flush it closes again at once.
    assign close_now  = accept && ((cnt_reg == LAST) || flush);
    assign flush_only = !accept && flush && (state_reg == ACCUM) && (cnt_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
        end else if (close_now) begin
            out_sum_reg   <= add_sum;
            out_count_reg <= cnt_reg + CNT_W'(1);
            out_sat_reg   <= sat_reg | add_sat;
            out_valid_reg <= 1'b1;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
            state_reg     <= HOLD;
        end else if (accept) begin
            acc_reg       <= add_sum;
            cnt_reg       <= cnt_reg + CNT_W'(1);
            sat_reg       <= sat_reg | add_sat;
            out_valid_reg <= 1'b0;
            state_reg     <= ACCUM;
        end else if (flush_only) begin
            out_sum_reg   <= acc_reg;
            out_count_reg <= cnt_reg;
            out_sat_reg   <= sat_reg;
            out_valid_reg <= 1'b1;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
            state_reg     <= HOLD;
        end else if ((state_reg == HOLD) && out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ACCUM;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign out_sat   = out_sat_reg;

endmodule
